// File: rtl/axi_wr_burst_gen_pkg.sv
// Shared types for the AXI write-burst front end.
package axi_wr_burst_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } burst_state_t;

endpackage

// File: rtl/axi_wr_burst_gen_fifo.sv
// Show-ahead synchronous FIFO: rd_data is the head entry in the same cycle.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_AW    = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wptr, rptr;
  logic                  push, pop;

  // level never exceeds DEPTH, so its top bit alone marks full
  assign full    = level[FIFO_AW];
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_burst_gen.sv
// Write-side front end: buffers the input stream and issues fixed-length, wrapping write bursts.
// Define WR_FLUSH_EN to add a flush input that bursts out leftover (< BURST_LEN) data.
module axi_wr_burst_gen
  import axi_wr_burst_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 27,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FIFO_AW    = 6,
  parameter logic [7:0]            BURST_LEN  = 8'd8,
  parameter int                    ADDR_INC   = 1,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = '1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_end,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  addr_rst,
  output logic                  wr_trig,
  output logic [7:0]            wr_len,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_en,
  input  logic                  wr_ready,
  input  logic                  wr_done,
`ifdef WR_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int AW1 = ADDR_WIDTH + 1;
  // Highest start address that still leaves room for a full burst before END_ADDR
  localparam logic [ADDR_WIDTH:0] ADDR_LIM =
    {1'b0, END_ADDR} - AW1'(BURST_LEN) * AW1'(ADDR_INC) + AW1'(1);

  burst_state_t        state, state_nxt;
  logic                full, empty;
  logic                go_full, go_flush;
  logic                rst_pend;
  logic [ADDR_WIDTH:0] addr_nxt;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (wr_data_en),
    .rd_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign in_ready = !full;
  assign go_full  = (state == IDLE) && init_end && wr_ready && !empty &&
                    (32'(fifo_level) >= 32'(BURST_LEN));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_trig   = 1'b0;
    unique case (state)
      IDLE: if (go_full || go_flush) state_nxt = REQ;
      REQ: begin
        wr_trig   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (wr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One bit wider than the address so a run past the top of the space is visible
  assign addr_nxt = {1'b0, wr_addr} + AW1'(wr_len) * AW1'(ADDR_INC);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_addr  <= START_ADDR;
      rst_pend <= 1'b0;
    end else if (state == WAIT && wr_done) begin
      wr_addr  <= (rst_pend || addr_rst || addr_nxt > ADDR_LIM) ? START_ADDR
                                                                : addr_nxt[ADDR_WIDTH-1:0];
      rst_pend <= 1'b0;
    end else if (addr_rst) begin
      if (state == IDLE) wr_addr  <= START_ADDR;
      else               rst_pend <= 1'b1;
    end
  end

`ifdef WR_FLUSH_EN
  logic flush_pend;

  assign go_flush = (state == IDLE) && flush_pend && init_end && wr_ready && !empty &&
                    (32'(fifo_level) < 32'(BURST_LEN));

  // A pending flush becomes moot once a full burst is buffered or nothing is left
  always_ff @(posedge clk) begin
    if (!rstn)                  flush_pend <= 1'b0;
    else if (go_flush)          flush_pend <= 1'b0;
    else if (flush)             flush_pend <= 1'b1;
    else if (empty || 32'(fifo_level) >= 32'(BURST_LEN))
                                flush_pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn)         wr_len <= BURST_LEN;
    else if (go_flush) wr_len <= 8'(fifo_level);
    else if (go_full)  wr_len <= BURST_LEN;
  end
`else
  assign go_flush = 1'b0;
  assign wr_len   = BURST_LEN;
`endif

endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// Bench for axi_wr_burst_gen: queue-based reference model, reactive master, directed and random phases.
module tb_axi_wr_burst_gen;

  localparam int AW    = 27;
  localparam int DW    = 16;
  localparam int FAW   = 6;
  localparam int DEPTH = 64;
  localparam int BL    = 8;
  localparam longint END_A = (64'd1 << AW) - 1;
  localparam longint END_B = 31;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          init_end = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          addr_rst = 1'b0;
  logic          wr_data_en = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_done = 1'b0;
`ifdef WR_FLUSH_EN
  logic          flush = 1'b0;
`endif

  logic          in_ready, wr_trig, b_in_ready, b_wr_trig;
  logic [7:0]    wr_len, b_wr_len;
  logic [AW-1:0] wr_addr, b_wr_addr;
  logic [DW-1:0] wr_data, b_wr_data;
  logic [FAW:0]  fifo_level, b_fifo_level;

  always #5 clk = ~clk;

  axi_wr_burst_gen dut (
    .clk(clk), .rstn(rstn), .init_end(init_end), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .addr_rst(addr_rst), .wr_trig(wr_trig), .wr_len(wr_len),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_ready(wr_ready),
    .wr_done(wr_done),
`ifdef WR_FLUSH_EN
    .flush(flush),
`endif
    .fifo_level(fifo_level)
  );

  // Same stimulus, small region: exercises the address wrap
  axi_wr_burst_gen #(.END_ADDR(27'd31)) dut31 (
    .clk(clk), .rstn(rstn), .init_end(init_end), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .addr_rst(addr_rst), .wr_trig(b_wr_trig), .wr_len(b_wr_len),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_data_en(wr_data_en), .wr_ready(wr_ready),
    .wr_done(wr_done),
`ifdef WR_FLUSH_EN
    .flush(flush),
`endif
    .fifo_level(b_fifo_level)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // reference model
  int     q[$];
  logic   md_trig, md_out, md_pend;
  longint md_addr, md_addr31;
  int     md_len;
`ifdef WR_FLUSH_EN
  logic   md_fpend;
`endif

  // master model and logs
  logic   ms_act = 1'b0, ms_donep = 1'b0, force_pop = 1'b0, stall = 1'b0;
  int     ms_dly, ms_left;
  int     trig_cnt;
  longint trig_addr[$], trig_addr31[$];
  int     trig_len[$], popped[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic longint next_addr(longint a, int len, logic rp, longint end_a);
    longint nxt = a + len;
    return (rp || nxt > end_a - BL + 1) ? 64'd0 : nxt;
  endfunction

  task automatic compare();
    if (!chk_en) return;
    chk("fifo_level", fifo_level, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("wr_trig", wr_trig, md_trig);
    chk("wr_len", wr_len, md_len);
    chk("wr_addr", wr_addr, md_addr);
    chk("b_fifo_level", b_fifo_level, q.size());
    chk("b_in_ready", b_in_ready, q.size() < DEPTH);
    chk("b_wr_trig", b_wr_trig, md_trig);
    chk("b_wr_len", b_wr_len, md_len);
    chk("b_wr_addr", b_wr_addr, md_addr31);
    if (q.size() > 0) begin
      chk("wr_data", wr_data, q[0]);
      chk("b_wr_data", b_wr_data, q[0]);
    end
  endtask

  task automatic master();
    wr_data_en = force_pop;
    wr_done    = 1'b0;
    if (!rstn) begin
      ms_act   = 1'b0;
      ms_donep = 1'b0;
    end else if (ms_donep) begin
      wr_done  = 1'b1;
      ms_donep = 1'b0;
      ms_act   = 1'b0;
    end else if (ms_act) begin
      if (ms_dly > 0) ms_dly--;
      else if (ms_left > 0 && $urandom_range(0, 3) != 0) begin
        wr_data_en = 1'b1;
        popped.push_back(int'(wr_data));
        ms_left--;
        if (ms_left == 0) ms_donep = 1'b1;
      end
    end
    if (rstn && wr_trig === 1'b1 && !ms_act) begin
      ms_act  = 1'b1;
      ms_left = md_len;
      ms_dly  = $urandom_range(1, 3);
      trig_cnt++;
      trig_addr.push_back(longint'(wr_addr));
      trig_addr31.push_back(longint'(b_wr_addr));
      trig_len.push_back(int'(wr_len));
    end
    wr_ready = !ms_act && !stall;
  endtask

  task automatic model_step();
    int   lvl = q.size();
    logic idle = !md_out && !md_trig;
    logic nt = 1'b0;
    logic rp;
    if (!rstn) begin
      q.delete();
      md_trig = 0; md_out = 0; md_pend = 0; md_addr = 0; md_addr31 = 0; md_len = BL;
`ifdef WR_FLUSH_EN
      md_fpend = 0;
`endif
      return;
    end
    if (idle && init_end && wr_ready && lvl >= BL) begin
      nt = 1'b1;
      md_len = BL;
    end
`ifdef WR_FLUSH_EN
    if (idle && init_end && wr_ready && md_fpend && lvl > 0 && lvl < BL) begin
      nt = 1'b1;
      md_len = lvl;
      md_fpend = 0;
    end else if (flush) md_fpend = 1;
    else if (lvl == 0 || lvl >= BL) md_fpend = 0;
`endif
    if (md_out && wr_done) begin
      rp        = md_pend || addr_rst;
      md_addr   = next_addr(md_addr, md_len, rp, END_A);
      md_addr31 = next_addr(md_addr31, md_len, rp, END_B);
      md_pend   = 0;
      md_out    = 0;
    end else if (addr_rst) begin
      if (idle) begin
        md_addr   = 0;
        md_addr31 = 0;
      end else md_pend = 1;
    end
    if (md_trig) md_out = 1;
    md_trig = nt;
    if (wr_data_en && lvl > 0) void'(q.pop_front());
    if (in_valid && lvl < DEPTH) q.push_back(int'(in_data));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    master();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    trig_cnt = 0;
    trig_addr.delete();
    trig_addr31.delete();
    trig_len.delete();
    popped.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; addr_rst = 1'b0; init_end = 1'b0; stall = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
    chk_en = 1'b1;
    clear_logs();
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_trigs(input int n, input int budget, input string nm);
    int c = 0;
    while ((trig_cnt < n || ms_act) && c < budget) begin
      cycle();
      c++;
    end
    chk(nm, trig_cnt, n);
  endtask

  initial begin
    int c;
    logic sent;
    clear_logs();

    // reset state
    do_reset();
    chk("rst_level", fifo_level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_trig", wr_trig, 0);
    chk("rst_wr_len", wr_len, 8);
    chk("rst_wr_addr", wr_addr, 0);

    // one burst of 0x0001..0x0008
    init_end = 1'b1;
    push_n(8, 1);
    wait_trigs(1, 100, "s1_bursts");
    chk("s1_addr", trig_addr.size() > 0 ? trig_addr[0] : -1, 0);
    chk("s1_len", trig_len.size() > 0 ? trig_len[0] : -1, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("s1_pop%0d", i), i < popped.size() ? popped[i] : -1, i + 1);
    chk("s1_next_addr", wr_addr, 8);

    // fill while init_end low, then drain as 8 back-to-back bursts
    do_reset();
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("s2_full_level", fifo_level, 64);
    chk("s2_full_ready", in_ready, 0);
    chk("s2_no_trig", trig_cnt, 0);
    init_end = 1'b1;
    wait_trigs(8, 400, "s2_bursts");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s2_addr%0d", i), i < trig_addr.size() ? trig_addr[i] : -1, i * 8);
      chk($sformatf("s2_addr31_%0d", i), i < trig_addr31.size() ? trig_addr31[i] : -1, (i % 4) * 8);
    end
    chk("s2_drained", fifo_level, 0);

    // addr_rst during the burst at 16
    do_reset();
    init_end = 1'b1;
    c = 0;
    sent = 1'b0;
    for (int pushed = 0; c < 400 && (trig_cnt < 4 || ms_act); c++) begin
      in_valid = (pushed < 32);
      in_data  = DW'($urandom);
      if (in_valid && in_ready) pushed++;
      addr_rst = (trig_cnt == 3 && ms_act && !sent);
      if (addr_rst) sent = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    addr_rst = 1'b0;
    chk("s3_bursts", trig_cnt, 4);
    chk("s3_addr3", trig_addr.size() > 3 ? trig_addr[3] : -1, 0);
    chk("s3_addr2", trig_addr.size() > 2 ? trig_addr[2] : -1, 16);

    // pop while empty, simultaneous push/pop, reset mid-burst
    do_reset();
    force_pop = 1'b1;
    cycle();
    force_pop = 1'b0;
    chk("s4_empty_pop", fifo_level, 0);
    push_n(5, 16'h50);
    in_valid = 1'b1;
    in_data  = 16'h5a;
    force_pop = 1'b1;
    cycle();
    in_valid = 1'b0;
    force_pop = 1'b0;
    chk("s4_push_pop", fifo_level, 5);
    init_end = 1'b1;
    push_n(11, 16'h60);
    c = 0;
    while (trig_cnt < 2 && c < 100) begin
      cycle();
      c++;
    end
    chk("s4_second_burst", trig_cnt, 2);
    cycle();
    cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("s4_rst_level", fifo_level, 0);
    chk("s4_rst_trig", wr_trig, 0);
    chk("s4_rst_addr", wr_addr, 0);
    chk("s4_rst_ready", in_ready, 1);

`ifdef WR_FLUSH_EN
    // flush of a 3-beat remainder
    do_reset();
    init_end = 1'b1;
    push_n(3, 16'ha1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    wait_trigs(1, 100, "s5_bursts");
    chk("s5_len", trig_len.size() > 0 ? trig_len[0] : -1, 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("s5_pop%0d", i), i < popped.size() ? popped[i] : -1, 16'ha1 + i);
    for (int i = 0; i < 30; i++) cycle();
    chk("s5_no_more", trig_cnt, 1);
    chk("s5_addr", wr_addr, 3);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      init_end = ($urandom_range(0, 19) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = DW'($urandom);
      addr_rst = ($urandom_range(0, 60) == 0);
      stall    = ($urandom_range(0, 4) == 0);
`ifdef WR_FLUSH_EN
      flush    = ($urandom_range(0, 30) == 0);
`endif
      cycle();
    end
    in_valid = 1'b0; addr_rst = 1'b0; stall = 1'b0; init_end = 1'b1;
`ifdef WR_FLUSH_EN
    flush = 1'b0;
`endif
    for (int i = 0; i < 200; i++) cycle();
    chk("rand_bursts_seen", trig_cnt > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
